// File: rtl/simultaneous_to_sequential_reg_pkg.sv
// ============================================================================
// Module      : simultaneous_to_sequential_reg_pkg
// Description : State encoding and width helpers shared by the parallel-in /
//               serial-out shift register and its hold counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package simultaneous_to_sequential_reg_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Degenerate zero-sized parameters are treated as one.
    function automatic int notBeingZero(input int value);
        return (value <= 0) ? 1 : value;
    endfunction

    // Bits needed to hold 'value'; never less than one.
    function automatic int bitWidthCal(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((value >> i) != 0) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_distance_counter.sv
// ============================================================================
// Module      : clk_distance_counter
// Description : Counts advancing cycles of the current symbol; 'wrap' flags the
//               last cycle of the hold period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_distance_counter
    import simultaneous_to_sequential_reg_pkg::*;
#(
    parameter int DISTANCE = 1
) (
    input  logic clk,
    input  logic in_ctr_Arst_n,
    input  logic clear,
    input  logic inc,
    output logic wrap
);

    localparam int c_DIST  = notBeingZero(DISTANCE);
    localparam int c_WIDTH = bitWidthCal(c_DIST - 1);

    logic [c_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign wrap = (r_cnt == c_WIDTH'(c_DIST - 1));

endmodule

`default_nettype wire

// File: rtl/simultaneous_to_sequential_reg.sv
// ============================================================================
// Module      : simultaneous_to_sequential_reg
// Description : Parallel-in / serial-out shift register, one symbol per hold
//               period, paced by a downstream shift-enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simultaneous_to_sequential_reg
    import simultaneous_to_sequential_reg_pkg::*;
#(
    parameter int DIRECTION    = 1,
    parameter int SHIFT_LEN    = 4,
    parameter int BIT_WIDTH    = 2,
    parameter int CLK_DISTANCE = 1
) (
    input  logic                           clk,
    input  logic                           in_ctr_Arst_n,
    input  logic                           in_ctr_Srst,
    input  logic                           in_ctr_en,
    input  logic                           in_ctr_ld,
    input  logic                           in_ctr_sh_en,
    input  logic [BIT_WIDTH*SHIFT_LEN-1:0] in,
    output logic [BIT_WIDTH-1:0]           out,
    output logic                           out_valid,
    output logic                           out_last,
    output logic                           out_ready,
    output logic                           out_drop
);

    localparam int c_TOTAL   = BIT_WIDTH * SHIFT_LEN;
    localparam int c_LEN     = notBeingZero(SHIFT_LEN);
    localparam int c_SYM_W   = bitWidthCal(c_LEN - 1);
    localparam int c_PENULT  = (c_LEN > 1) ? (c_LEN - 2) : 0;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_TOTAL-1:0]   r_word;
    logic [c_TOTAL-1:0]   w_word_shift;
    logic [BIT_WIDTH-1:0] r_out;
    logic [BIT_WIDTH-1:0] w_first_sym;
    logic [BIT_WIDTH-1:0] w_next_sym;
    logic [c_SYM_W-1:0]   r_sym_cnt;
    logic                 r_last;
    logic                 r_drop;
    logic                 w_shifting;
    logic                 w_dis_wrap;
    logic                 w_adv;
    logic                 w_done;
    logic                 w_ready;
    logic                 w_load;

    assign w_shifting = (r_state == ST_SHIFT);
    assign w_adv      = in_ctr_en & in_ctr_sh_en & w_shifting & w_dis_wrap;
    assign w_done     = w_adv & (r_sym_cnt == c_SYM_W'(c_LEN - 1));
    assign w_ready    = ~w_shifting | w_done;
    assign w_load     = in_ctr_en & in_ctr_ld & w_ready;

    clk_distance_counter #(
        .DISTANCE (CLK_DISTANCE)
    ) u_dis_cnt (
        .clk           (clk),
        .in_ctr_Arst_n (in_ctr_Arst_n),
        .clear         (in_ctr_Srst | w_adv | w_load),
        .inc           (in_ctr_en & in_ctr_sh_en & w_shifting),
        .wrap          (w_dis_wrap)
    );

    // The output end of the word register is the top slice or slice 0.
    generate
        if (DIRECTION > 0) begin : g_msb_first
            assign w_first_sym  = in[c_TOTAL-1 -: BIT_WIDTH];
            assign w_word_shift = r_word << BIT_WIDTH;
            assign w_next_sym   = w_word_shift[c_TOTAL-1 -: BIT_WIDTH];
        end else begin : g_lsb_first
            assign w_first_sym  = in[BIT_WIDTH-1:0];
            assign w_word_shift = r_word >> BIT_WIDTH;
            assign w_next_sym   = w_word_shift[BIT_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            r_state <= ST_IDLE;
        end else if (in_ctr_Srst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_load) begin
            w_state_next = ST_SHIFT;
        end else if (w_done) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            r_word    <= '0;
            r_out     <= '0;
            r_sym_cnt <= '0;
            r_last    <= 1'b0;
            r_drop    <= 1'b0;
        end else if (in_ctr_Srst) begin
            r_word    <= '0;
            r_out     <= '0;
            r_sym_cnt <= '0;
            r_last    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_drop <= in_ctr_en & in_ctr_ld & ~w_ready;
            if (w_load) begin
                r_word    <= in;
                r_out     <= w_first_sym;
                r_sym_cnt <= '0;
                r_last    <= (c_LEN == 1);
            end else if (w_done) begin
                r_last <= 1'b0;
            end else if (w_adv) begin
                r_word    <= w_word_shift;
                r_out     <= w_next_sym;
                r_sym_cnt <= r_sym_cnt + 1'b1;
                r_last    <= (r_sym_cnt == c_SYM_W'(c_PENULT));
            end
        end
    end

    assign out       = r_out;
    assign out_valid = w_shifting;
    assign out_last  = r_last;
    assign out_ready = w_ready;
    assign out_drop  = r_drop;

endmodule

`default_nettype wire
